// File: rtl/g15_pkg.sv
// Shared drum-machine definitions: drum geometry, command-line writer states
// and the result codes reported on STATUS.
package g15_pkg;

    localparam int WORD_BITS     = 29;
    localparam int WORDS_PER_REV = 108;
    localparam int CNT_W         = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_WR,
        S_WRITE,
        S_WAIT_VF,
        S_VERIFY,
        S_FINISH
    } state_t;

    typedef enum logic [1:0] {
        ST_OK       = 2'b00,
        ST_MISMATCH = 2'b01,
        ST_BAD_ADDR = 2'b10,
        ST_ABORTED  = 2'b11
    } status_t;

endpackage

// File: rtl/cmd_line_writer.sv
// Writes one command word onto a drum line at a requested word time, then
// reads it back one revolution later and reports whether it verified.
module cmd_line_writer #(
    parameter int WORD_BITS     = g15_pkg::WORD_BITS,
    parameter int WORDS_PER_REV = g15_pkg::WORDS_PER_REV
) (
    input  logic                 CLOCK,
    input  logic                 rst_n,
    input  logic                 T0,
    input  logic [6:0]           WT,
    input  logic                 REQ,
    input  logic [6:0]           REQ_ADDR,
    input  logic [WORD_BITS-1:0] REQ_WORD,
    input  logic                 ABORT,
    input  logic                 RD,
    output logic                 ACK,
    output logic                 BUSY,
    output logic                 WE,
    output logic                 WD,
    output logic                 DONE,
    output logic [1:0]           STATUS
);
    import g15_pkg::*;

    localparam logic [6:0]       LAST_WT  = 7'(WORDS_PER_REV - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);

    state_t               state;
    status_t              status_q;
    logic [CNT_W-1:0]     cnt;
    logic [WORD_BITS-1:0] shadow;
    logic [6:0]           addr;
    logic                 mismatch;
    logic                 abort_q;

    logic match;
    logic last_bit;
    logic bit_mis;
    logic mis_next;

    // Word times beyond the end of the revolution can never be a target.
    assign match    = T0 && (WT <= LAST_WT) && (WT == addr);
    assign last_bit = (cnt == LAST_BIT);
    assign bit_mis  = (RD != shadow[cnt]);
    assign mis_next = mismatch | bit_mis;
    assign STATUS   = status_q;

    // Bit 0 must go out in the same clock the match is seen, so WE/WD are
    // Mealy; an abort on that clock suppresses it to avoid a 1-bit fragment.
    always_comb begin
        WE = 1'b0;
        WD = 1'b0;
        case (state)
            S_WAIT_WR: begin
                if (match && !ABORT) begin
                    WE = 1'b1;
                    WD = shadow[0];
                end
            end
            S_WRITE: begin
                WE = 1'b1;
                WD = shadow[cnt];
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            status_q <= ST_OK;
            cnt      <= '0;
            shadow   <= '0;
            addr     <= '0;
            mismatch <= 1'b0;
            abort_q  <= 1'b0;
            ACK      <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            ACK  <= 1'b0;
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (REQ) begin
                        ACK      <= 1'b1;
                        BUSY     <= 1'b1;
                        addr     <= REQ_ADDR;
                        shadow   <= REQ_WORD;
                        mismatch <= 1'b0;
                        abort_q  <= 1'b0;
                        cnt      <= '0;
                        if (REQ_ADDR > LAST_WT) begin
                            state    <= S_FINISH;
                            DONE     <= 1'b1;
                            status_q <= ST_BAD_ADDR;
                        end else begin
                            state    <= S_WAIT_WR;
                            status_q <= ST_OK;
                        end
                    end
                end
                S_WAIT_WR: begin
                    if (ABORT) begin
                        state    <= S_FINISH;
                        DONE     <= 1'b1;
                        status_q <= ST_ABORTED;
                        cnt      <= '0;
                    end else if (match) begin
                        state <= S_WRITE;
                        cnt   <= CNT_W'(1);
                    end
                end
                S_WRITE: begin
                    // An abort here is deferred so the line never holds a partial word.
                    if (last_bit) begin
                        cnt <= '0;
                        if (abort_q || ABORT) begin
                            state    <= S_FINISH;
                            DONE     <= 1'b1;
                            status_q <= ST_ABORTED;
                        end else begin
                            state <= S_WAIT_VF;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (ABORT)
                            abort_q <= 1'b1;
                    end
                end
                S_WAIT_VF: begin
                    if (ABORT) begin
                        state    <= S_FINISH;
                        DONE     <= 1'b1;
                        status_q <= ST_ABORTED;
                        cnt      <= '0;
                    end else if (match) begin
                        mismatch <= bit_mis;
                        state    <= S_VERIFY;
                        cnt      <= CNT_W'(1);
                    end
                end
                S_VERIFY: begin
                    if (ABORT) begin
                        state    <= S_FINISH;
                        DONE     <= 1'b1;
                        status_q <= ST_ABORTED;
                        cnt      <= '0;
                    end else if (last_bit) begin
                        mismatch <= mis_next;
                        state    <= S_FINISH;
                        DONE     <= 1'b1;
                        status_q <= mis_next ? ST_MISMATCH : ST_OK;
                        cnt      <= '0;
                    end else begin
                        mismatch <= mis_next;
                        cnt      <= cnt + CNT_W'(1);
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                    cnt   <= '0;
                end
                default: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_line_writer.sv
// Bench for cmd_line_writer: a drum model supplies T0/WT and loops written
// bits back on RD one revolution later.
module tb_cmd_line_writer;

    localparam int WB  = 29;
    localparam int WPR = 108;
    localparam int REV = WB * WPR;

    logic          CLOCK = 1'b0;
    logic          rst_n;
    logic          T0;
    logic [6:0]    WT;
    logic          REQ;
    logic [6:0]    REQ_ADDR;
    logic [WB-1:0] REQ_WORD;
    logic          ABORT;
    logic          RD;
    logic          ACK, BUSY, WE, WD, DONE;
    logic [1:0]    STATUS;

    cmd_line_writer dut (
        .CLOCK(CLOCK), .rst_n(rst_n), .T0(T0), .WT(WT), .REQ(REQ),
        .REQ_ADDR(REQ_ADDR), .REQ_WORD(REQ_WORD), .ABORT(ABORT), .RD(RD),
        .ACK(ACK), .BUSY(BUSY), .WE(WE), .WD(WD), .DONE(DONE), .STATUS(STATUS)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [6:0]    addr;
        logic [WB-1:0] word;
        int            flip_bit;   // verify-pass bit to corrupt on RD, -1 none
        int            abort_bit;  // write bit at which ABORT pulses, -1 none
        logic [1:0]    exp_status;
        int            exp_we;
    } vec_t;

    vec_t tbl[8];
    logic mem[REV];
    int   pos;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance the drum one bit time at the falling edge.
    task automatic cyc();
        @(negedge CLOCK);
        pos = (pos + 1) % REV;
        T0  = (pos % WB) == 0;
        WT  = 7'(pos / WB);
        RD  = mem[pos];
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        int we_cnt, we_first, we_first_pos, done_at, done_cnt, wd_bad, extra_ack, exp_done;
        logic ack1;
        logic gap;
        logic [1:0] st;
        we_cnt = 0; we_first = 0; we_first_pos = -1; done_at = 0; done_cnt = 0;
        wd_bad = 0; extra_ack = 0; ack1 = 1'b0; gap = 1'b0; st = 2'b00;
        pos = ((32'(v.addr) + 105) % WPR) * WB;
        cyc();
        REQ = 1'b1; REQ_ADDR = v.addr; REQ_WORD = v.word;
        #1;
        for (int c = 1; c < 3 * REV; c++) begin
            cyc();
            REQ   = 1'b0;
            ABORT = (v.abort_bit >= 0) && (we_cnt == v.abort_bit);
            if (v.flip_bit >= 0 && we_cnt == WB && WT == v.addr && (pos % WB) == v.flip_bit)
                RD = ~RD;
            #1;
            if (c == 1) ack1 = ACK;
            else if (ACK) extra_ack++;
            if (WE) begin
                if (we_cnt == 0) begin
                    we_first = c;
                    we_first_pos = pos;
                end else if (we_first + we_cnt != c) begin
                    gap = 1'b1;
                end
                if (we_cnt < WB && WD !== v.word[we_cnt]) wd_bad++;
                mem[pos] = WD;
                we_cnt++;
            end
            if (DONE) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_at = c;
                    st = STATUS;
                end
            end
            if (done_cnt > 0 && c == done_at + 2) break;
        end
        ABORT = 1'b0;
        if (v.exp_status == 2'b10)      exp_done = 1;
        else if (v.exp_status == 2'b11) exp_done = we_first + WB;
        else                            exp_done = we_first + REV + WB;
        $display("vector %0d addr=%0d", idx, v.addr);
        chk("ack_pulse", 32'(ack1), 32'd1);
        chk("ack_extra", extra_ack, 0);
        chk("we_count", we_cnt, v.exp_we);
        chk("we_gap", 32'(gap), 32'd0);
        chk("wd_data", wd_bad, 0);
        if (v.exp_we > 0) chk("we_start_pos", we_first_pos, 32'(v.addr) * WB);
        chk("done_count", done_cnt, 1);
        chk("done_time", done_at, exp_done);
        chk("status", 32'(st), 32'(v.exp_status));
        chk("status_held", 32'(STATUS), 32'(v.exp_status));
        chk("busy_after", 32'(BUSY), 32'd0);
    endtask

    initial begin
        int n_we, n_busy, ack_extra;
        logic we_seen;
        for (int i = 0; i < REV; i++) mem[i] = 1'b0;
        pos = 0; rst_n = 1'b0; T0 = 1'b0; WT = '0; REQ = 1'b0; REQ_ADDR = '0;
        REQ_WORD = '0; ABORT = 1'b0; RD = 1'b0;

        tbl[0] = '{7'd5,   29'h0AAAAAAA, -1, -1, 2'b00, 29};
        tbl[1] = '{7'd5,   29'h0AAAAAAA, 17, -1, 2'b01, 29};
        tbl[2] = '{7'd108, 29'h1FFFFFFF, -1, -1, 2'b10, 0};
        tbl[3] = '{7'd107, 29'h01234567, -1, -1, 2'b00, 29};
        tbl[4] = '{7'd0,   29'h1FFFFFFF, -1, -1, 2'b00, 29};
        tbl[5] = '{7'd40,  29'h00F0F0F0, -1, 10, 2'b11, 29};
        tbl[6] = '{7'd20,  29'h13579BDF, 28, -1, 2'b01, 29};
        tbl[7] = '{7'd21,  29'h13579BDF, 0,  -1, 2'b01, 29};

        cyc(); cyc(); #1;
        chk("rst_ack", 32'(ACK), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_we", 32'(WE), 0);
        chk("rst_wd", 32'(WD), 0);
        chk("rst_done", 32'(DONE), 0);
        chk("rst_status", 32'(STATUS), 0);
        cyc(); rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_txn(i, tbl[i]);

        // Abort while waiting for the write slot.
        pos = 0; we_seen = 1'b0;
        cyc(); REQ = 1'b1; REQ_ADDR = 7'd50; REQ_WORD = 29'h1; #1;
        cyc(); REQ = 1'b0; ABORT = 1'b1; #1;
        chk("abwait_ack", 32'(ACK), 1);
        we_seen |= WE;
        cyc(); ABORT = 1'b0; #1;
        chk("abwait_done", 32'(DONE), 1);
        chk("abwait_status", 32'(STATUS), 2'b11);
        we_seen |= WE;
        cyc(); #1;
        chk("abwait_busy", 32'(BUSY), 0);
        chk("abwait_we", 32'(we_seen), 0);

        // REQ held high: ignored while busy, taken on the first IDLE clock.
        pos = 0; ack_extra = 0;
        cyc(); REQ = 1'b1; REQ_ADDR = 7'd60; #1;
        for (int i = 1; i <= 7; i++) begin
            cyc(); ABORT = (i == 4); #1;
            if (i == 1) chk("hold_ack_first", 32'(ACK), 1);
            else if (i < 7 && ACK) ack_extra++;
            if (i == 5) chk("hold_done", 32'(DONE), 1);
            if (i == 7) chk("hold_ack_reaccept", 32'(ACK), 1);
        end
        chk("hold_no_ack_busy", ack_extra, 0);
        REQ = 1'b0;
        cyc(); ABORT = 1'b1; #1;
        cyc(); ABORT = 1'b0; #1;
        chk("hold_done2", 32'(DONE), 1);
        cyc(); #1;

        // Reset in the middle of a write to the last word time.
        pos = 104 * WB; n_we = 0;
        cyc(); REQ = 1'b1; REQ_ADDR = 7'd107; REQ_WORD = 29'h15555555; #1;
        for (int c = 0; c < 2 * REV; c++) begin
            cyc(); REQ = 1'b0; #1;
            if (WE) begin
                if (n_we == 12) begin
                    rst_n = 1'b0; #1;
                    chk("rstw_we", 32'(WE), 0);
                    chk("rstw_busy", 32'(BUSY), 0);
                    chk("rstw_status", 32'(STATUS), 0);
                    break;
                end
                n_we++;
            end
        end
        chk("rstw_reached_bit12", n_we, 12);
        cyc(); cyc(); rst_n = 1'b1;
        n_we = 0; n_busy = 0;
        for (int c = 0; c < REV + 40; c++) begin
            cyc(); #1;
            if (WE) n_we++;
            if (BUSY) n_busy++;
        end
        chk("rstw_no_resume_we", n_we, 0);
        chk("rstw_no_resume_busy", n_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
